// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter feeding a single registered CDB entry, with epoch-based squash.
// Define WB_ARB_STATS_EN to add the saturating stale_drop_cnt output.
module wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int ROB_W   = 5,
  parameter int PHYS_W  = 6,
  parameter int EPOCH_W = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SRC-1:0]               src_valid,
  output logic [NUM_SRC-1:0]               src_ready,
  input  logic [NUM_SRC-1:0][31:0]         src_pc,
  input  logic [NUM_SRC-1:0][31:0]         src_data,
  input  logic [NUM_SRC-1:0]               src_uses_rd,
  input  logic [NUM_SRC-1:0][ROB_W-1:0]    src_rob_idx,
  input  logic [NUM_SRC-1:0][PHYS_W-1:0]   src_prd_new,
  input  logic [NUM_SRC-1:0][EPOCH_W-1:0]  src_epoch,
  input  logic [EPOCH_W-1:0]               cur_epoch,
  input  logic                             flush,
  output logic                             cdb_valid,
  input  logic                             cdb_ready,
  output logic [31:0]                      cdb_pc,
  output logic [31:0]                      cdb_data,
  output logic                             cdb_uses_rd,
  output logic [ROB_W-1:0]                 cdb_rob_idx,
  output logic [PHYS_W-1:0]                cdb_prd_new,
  output logic [EPOCH_W-1:0]               cdb_epoch
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]                      stale_drop_cnt
`endif
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W:0]   NUM_S = (PTR_W+1)'(NUM_SRC);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_SRC - 1);

  logic                 out_vld;
  logic [31:0]          out_pc;
  logic [31:0]          out_data;
  logic                 out_uses_rd;
  logic [ROB_W-1:0]     out_rob_idx;
  logic [PHYS_W-1:0]    out_prd_new;
  logic [EPOCH_W-1:0]   out_epoch;
  logic [PTR_W-1:0]     rr_ptr;

  logic [NUM_SRC-1:0]   src_stale;
  logic [NUM_SRC-1:0]   cand;
  logic                 out_stale;
  logic                 out_free;
  logic                 found;
  logic                 grant;
  logic [PTR_W-1:0]     win;
  logic [PTR_W:0]       idx;

  assign out_stale   = out_vld && (out_epoch != cur_epoch);
  assign cdb_valid   = out_vld && (out_epoch == cur_epoch);
  assign out_free    = !out_vld || cdb_ready || out_stale;
  assign grant       = found && out_free && !flush;

  assign cdb_pc      = out_pc;
  assign cdb_data    = out_data;
  assign cdb_uses_rd = out_uses_rd;
  assign cdb_rob_idx = out_rob_idx;
  assign cdb_prd_new = out_prd_new;
  assign cdb_epoch   = out_epoch;

  // Search from rr_ptr upward with wrap; first valid, current-epoch source wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_stale[i] = (src_epoch[i] != cur_epoch);
      cand[i]      = src_valid[i] && !src_stale[i];
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= NUM_S) idx = idx - NUM_S;
      if (!found && cand[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (flush || src_stale[i])
        src_ready[i] = 1'b1;
      else if (grant && (win == PTR_W'(i)))
        src_ready[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld     <= 1'b0;
      out_pc      <= '0;
      out_data    <= '0;
      out_uses_rd <= 1'b0;
      out_rob_idx <= '0;
      out_prd_new <= '0;
      out_epoch   <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (grant) begin
      out_vld     <= 1'b1;
      out_pc      <= src_pc[win];
      out_data    <= src_data[win];
      out_uses_rd <= src_uses_rd[win];
      out_rob_idx <= src_rob_idx[win];
      out_prd_new <= src_prd_new[win];
      out_epoch   <= src_epoch[win];
      rr_ptr      <= (win == LAST) ? '0 : win + 1'b1;
    end else if (out_stale || (cdb_valid && cdb_ready)) begin
      out_vld <= 1'b0;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [16:0] drops;
  logic [16:0] drop_sum;

  // Discarded source transfers plus a squashed output entry, summed per cycle.
  always_comb begin
    drops = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (src_valid[i] && (flush || src_stale[i])) drops = drops + 17'd1;
    if (out_stale) drops = drops + 17'd1;
    drop_sum = {1'b0, stale_drop_cnt} + drops;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stale_drop_cnt <= '0;
    else
      stale_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: round-robin order, stall, epoch squash, flush, reset.
// Inputs change 1 time unit after a rising edge; outputs are checked before the next edge.
module tb_wb_arbiter;

  localparam int NUM_SRC = 3;
  localparam int ROB_W   = 5;
  localparam int PHYS_W  = 6;
  localparam int EPOCH_W = 3;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic [NUM_SRC-1:0]              src_valid;
  logic [NUM_SRC-1:0]              src_ready;
  logic [NUM_SRC-1:0][31:0]        src_pc;
  logic [NUM_SRC-1:0][31:0]        src_data;
  logic [NUM_SRC-1:0]              src_uses_rd;
  logic [NUM_SRC-1:0][ROB_W-1:0]   src_rob_idx;
  logic [NUM_SRC-1:0][PHYS_W-1:0]  src_prd_new;
  logic [NUM_SRC-1:0][EPOCH_W-1:0] src_epoch;
  logic [EPOCH_W-1:0]              cur_epoch;
  logic                            flush;
  logic                            cdb_valid;
  logic                            cdb_ready;
  logic [31:0]                     cdb_pc;
  logic [31:0]                     cdb_data;
  logic                            cdb_uses_rd;
  logic [ROB_W-1:0]                cdb_rob_idx;
  logic [PHYS_W-1:0]               cdb_prd_new;
  logic [EPOCH_W-1:0]              cdb_epoch;
`ifdef WB_ARB_STATS_EN
  logic [15:0]                     stale_drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(.NUM_SRC(NUM_SRC), .ROB_W(ROB_W), .PHYS_W(PHYS_W), .EPOCH_W(EPOCH_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_pc(src_pc), .src_data(src_data), .src_uses_rd(src_uses_rd),
    .src_rob_idx(src_rob_idx), .src_prd_new(src_prd_new), .src_epoch(src_epoch),
    .cur_epoch(cur_epoch), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_pc(cdb_pc), .cdb_data(cdb_data), .cdb_uses_rd(cdb_uses_rd),
    .cdb_rob_idx(cdb_rob_idx), .cdb_prd_new(cdb_prd_new), .cdb_epoch(cdb_epoch)
`ifdef WB_ARB_STATS_EN
    , .stale_drop_cnt(stale_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_SRC-1:0] valid, input logic ready);
    src_valid = valid;
    cdb_ready = ready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    cur_epoch = '0;
    src_valid = '0;
    cdb_ready = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_pc[i]      = 32'h100 + 32'(4 * i);
      src_data[i]    = 32'hA000_0000 + 32'(i);
      src_uses_rd[i] = 1'b1;
      src_rob_idx[i] = ROB_W'(i);
      src_prd_new[i] = PHYS_W'(10 + i);
      src_epoch[i]   = '0;
    end
    #2;
    checkOutput("reset_cdb_valid", 32'(cdb_valid), 32'd0);
    checkOutput("reset_src_ready", 32'(src_ready), 32'd0);
    checkOutput("reset_rob_idx", 32'(cdb_rob_idx), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;

    // Continuous round robin: grant order 0,1,2,0
    $display("[TB] round robin");
    applyStimulus(3'b111, 1'b1);
    checkOutput("rr_first_ready", 32'(src_ready), 32'b001);
    tick();
    checkOutput("rr_c1_valid", 32'(cdb_valid), 32'd1);
    checkOutput("rr_c1_rob", 32'(cdb_rob_idx), 32'd0);
    checkOutput("rr_c1_data", cdb_data, 32'hA000_0000);
    checkOutput("rr_c1_ready", 32'(src_ready), 32'b010);
    tick();
    checkOutput("rr_c2_rob", 32'(cdb_rob_idx), 32'd1);
    checkOutput("rr_c2_pc", cdb_pc, 32'h104);
    checkOutput("rr_c2_ready", 32'(src_ready), 32'b100);
    tick();
    checkOutput("rr_c3_rob", 32'(cdb_rob_idx), 32'd2);
    checkOutput("rr_c3_prd", 32'(cdb_prd_new), 32'd12);
    tick();
    checkOutput("rr_c4_rob", 32'(cdb_rob_idx), 32'd0);
    applyStimulus(3'b000, 1'b1);
    checkOutput("idle_ready", 32'(src_ready), 32'd0);
    tick();
    checkOutput("idle_cdb_valid", 32'(cdb_valid), 32'd0);

    // Stall: source 1 granted, payload held while cdb_ready=0
    $display("[TB] stall");
    applyStimulus(3'b010, 1'b0);
    checkOutput("stall_grant_ready", 32'(src_ready), 32'b010);
    tick();
    src_data[1] = 32'hDEAD_BEEF;
    #1;
    for (int c = 0; c < 3; c++) begin
      checkOutput("stall_valid", 32'(cdb_valid), 32'd1);
      checkOutput("stall_data", cdb_data, 32'hA000_0001);
      checkOutput("stall_ready", 32'(src_ready), 32'd0);
      tick();
    end
    applyStimulus(3'b010, 1'b1);
    checkOutput("stall_release_ready", 32'(src_ready), 32'b010);
    applyStimulus(3'b000, 1'b1);
    tick();
    checkOutput("stall_drained", 32'(cdb_valid), 32'd0);
    src_data[1] = 32'hA000_0001;

    // Stale source 2 is acked and dropped
    $display("[TB] stale source");
    src_epoch[2] = 3'd1;
    applyStimulus(3'b100, 1'b1);
    checkOutput("stale_src_ready", 32'(src_ready), 32'b100);
    tick();
    checkOutput("stale_no_cdb", 32'(cdb_valid), 32'd0);
`ifdef WB_ARB_STATS_EN
    checkOutput("stale_cnt", 32'(stale_drop_cnt), 32'd1);
`endif
    src_epoch[2] = '0;
    applyStimulus(3'b000, 1'b1);

    // Held entry squashed by epoch change; waiting source granted in the same cycle
    $display("[TB] epoch change");
    applyStimulus(3'b001, 1'b0);
    checkOutput("ep_grant0", 32'(src_ready), 32'b001);
    tick();
    checkOutput("ep_held", 32'(cdb_valid), 32'd1);
    cur_epoch = 3'd1;
    for (int i = 0; i < NUM_SRC; i++) src_epoch[i] = 3'd1;
    applyStimulus(3'b010, 1'b0);
    checkOutput("ep_squash_now", 32'(cdb_valid), 32'd0);
    checkOutput("ep_regrant", 32'(src_ready), 32'b010);
    tick();
    checkOutput("ep_new_valid", 32'(cdb_valid), 32'd1);
    checkOutput("ep_new_rob", 32'(cdb_rob_idx), 32'd1);
    checkOutput("ep_new_epoch", 32'(cdb_epoch), 32'd1);
`ifdef WB_ARB_STATS_EN
    checkOutput("ep_cnt", 32'(stale_drop_cnt), 32'd2);
`endif

    // Flush with all sources valid and an entry held
    $display("[TB] flush");
    flush = 1'b1;
    applyStimulus(3'b111, 1'b0);
    checkOutput("flush_ready", 32'(src_ready), 32'b111);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flush_cleared", 32'(cdb_valid), 32'd0);
`ifdef WB_ARB_STATS_EN
    checkOutput("flush_cnt", 32'(stale_drop_cnt), 32'd5);
`endif
    applyStimulus(3'b111, 1'b0);
    checkOutput("flush_rr_held", 32'(src_ready), 32'b100);
    tick();
    checkOutput("flush_next_rob", 32'(cdb_rob_idx), 32'd2);

    // Reset mid-stall clears the entry without a clock edge
    $display("[TB] reset mid-stall");
    applyStimulus(3'b000, 1'b0);
    checkOutput("pre_reset_valid", 32'(cdb_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(cdb_valid), 32'd0);
    checkOutput("async_reset_rob", 32'(cdb_rob_idx), 32'd0);
`ifdef WB_ARB_STATS_EN
    checkOutput("async_reset_cnt", 32'(stale_drop_cnt), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    applyStimulus(3'b111, 1'b1);
    checkOutput("post_reset_ready", 32'(src_ready), 32'b001);
    tick();
    checkOutput("post_reset_rob0", 32'(cdb_rob_idx), 32'd0);
    tick();
    checkOutput("post_reset_rob1", 32'(cdb_rob_idx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
